// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The optional FETCH_MISPREDICT_CNT_EN counter lives in fetch_unit.sv.
package fetch_unit_pkg;

   localparam int PC_W    = 64;
   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DROP  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus: one outstanding request at a time,
// response is a single-cycle rvalid pulse.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic               req;
   logic [PC_W-1:0]    addr;
   logic               gnt;
   logic               rvalid;
   logic [INSTR_W-1:0] rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register. Flush beats load, and load beats consume, so a new
// instruction arriving in the cycle ID drains the old one is kept.
module fetch_unit_if_id_reg
   import fetch_unit_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               load,
   input  logic               consume,
   input  logic [PC_W-1:0]    pc_in,
   input  logic [INSTR_W-1:0] instr_in,
   output logic               valid,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] instr
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         pc    <= '0;
         instr <= NOP_INSTR;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= pc_in;
         instr <= instr_in;
      end else if (consume) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one request at a time, fills IF/ID, follows
// predictor / redirects. Optional FETCH_MISPREDICT_CNT_EN adds mispredict_cnt.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_ISSUE | request pc_q once IF/ID has room; hold addr until granted
// ST_WAIT  | request accepted, waiting for the response pulse
// ST_DROP  | a redirect orphaned the in-flight request; swallow its response
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 64'h0000_0000_0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PC_W-1:0]    predicted_pc,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   fetch_unit_if.master       imem,
   output logic [PC_W-1:0]    current_pc,
   output logic [INSTR_W-1:0] next_instruction,
   output logic               id_valid,
   output logic [PC_W-1:0]    id_pc,
   output logic [INSTR_W-1:0] id_instr,
   input  logic               id_ready
`ifdef FETCH_MISPREDICT_CNT_EN
   ,
   output logic [31:0]        mispredict_cnt
`endif
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            req;
   logic            load;
   logic            slot_free;

   assign slot_free = ~id_valid | id_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_ISSUE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      req     = 1'b0;
      load    = 1'b0;
      case (state_q)
         ST_ISSUE: begin
            req = slot_free & ~rst;
            if (redirect)
               state_d = (req & imem.gnt) ? ST_DROP : ST_ISSUE;
            else if (req & imem.gnt)
               state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (redirect) begin
               state_d = imem.rvalid ? ST_ISSUE : ST_DROP;
            end else if (imem.rvalid) begin
               load    = 1'b1;
               pc_d    = predicted_pc;
               state_d = ST_ISSUE;
            end
         end
         ST_DROP: begin
            // The orphaned response always retires the outstanding request,
            // even if another redirect lands on the same cycle.
            if (imem.rvalid)
               state_d = ST_ISSUE;
         end
         default: state_d = ST_ISSUE;
      endcase
      if (redirect)
         pc_d = redirect_pc;
   end

   assign imem.req         = req;
   assign imem.addr        = pc_q;
   assign current_pc       = pc_q;
   assign next_instruction = imem.rdata;

   fetch_unit_if_id_reg u_if_id_reg (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect),
      .load     (load),
      .consume  (id_ready),
      .pc_in    (pc_q),
      .instr_in (imem.rdata),
      .valid    (id_valid),
      .pc       (id_pc),
      .instr    (id_instr)
   );

`ifdef FETCH_MISPREDICT_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mispredict_cnt <= '0;
      else if (redirect && (mispredict_cnt != 32'hFFFF_FFFF))
         mispredict_cnt <= mispredict_cnt + 32'd1;
   end
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 64'h0000_0000_0000_0000, first fetch address after reset.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 predicted_pc  in  64  next PC from branch predictor, valid in the cycle imem_rvalid=1.
REQ-005 redirect  in  1  prediction_failed from the branch predictor; flush and refetch.
REQ-006 redirect_pc  in  64  correct_pc from ID, sampled when redirect=1.
REQ-007 imem_req  out  1  instruction memory request.
REQ-008 imem_addr  out  64  request address (= pc_q).
REQ-009 imem_gnt  in  1  memory accepts request this cycle.
REQ-010 imem_rvalid  in  1  one-cycle response pulse; at most one outstanding request.
REQ-011 imem_rdata  in  32  instruction word, valid with imem_rvalid.
REQ-012 current_pc  out  64  PC of the in-flight fetch (to predictor).
REQ-013 next_instruction  out  32  imem_rdata passthrough (to predictor).
REQ-014 id_valid  out  1  IF/ID register holds a valid instruction.
REQ-015 id_pc  out  64  PC of IF/ID instruction.
REQ-016 id_instr  out  32  IF/ID instruction.
REQ-017 id_ready  in  1  ID consumes IF/ID contents this cycle when id_valid=1.

Function
REQ-018 FSM states: ISSUE, WAIT, DROP.
REQ-019 slot_free = ~id_valid | id_ready; ISSUE asserts imem_req only when slot_free.
REQ-020 ISSUE: imem_req & imem_gnt -> WAIT; otherwise remain ISSUE holding imem_addr stable.
REQ-021 WAIT: imem_rvalid -> load id_valid=1, id_pc=pc_q, id_instr=imem_rdata; pc_q <= predicted_pc; -> ISSUE.
REQ-022 Without imem_rvalid, id_valid clears when id_ready=1; new instruction and consume in same cycle: new data wins.
REQ-023 Redirect (highest priority, any state): pc_q <= redirect_pc, id_valid <= 0, same edge.
REQ-024 Redirect in WAIT without rvalid, or in ISSUE with imem_gnt=1 -> DROP; redirect in WAIT with rvalid, or ISSUE without gnt -> ISSUE; rvalid data in redirect cycle discarded.
REQ-025 DROP: imem_req=0; discard next imem_rvalid (no IF/ID load, pc_q unchanged) -> ISSUE; redirect in DROP updates pc_q only, stays DROP.
REQ-026 current_pc = pc_q; next_instruction = imem_rdata, combinational.
REQ-027 Fetch latency: rvalid to id_valid = 1 cycle; throughput 1 instr per 2 cycles minimum with 1-cycle memory.
REQ-028 pc arithmetic is 64-bit, wraps modulo 2^64; no alignment check.

Reset
REQ-029 rst=1: state=ISSUE, pc_q=RESET_PC, id_valid=0, id_pc=0, id_instr=32'h0000_0013 (NOP), imem_req=0 during reset.
REQ-030 Reset asserted with request outstanding: late imem_rvalid after reset release while in ISSUE is ignored.

Configuration
REQ-031 Macro FETCH_MISPREDICT_CNT_EN: when defined, output mispredict_cnt [31:0] counts cycles with redirect=1, reset 0, saturates at 32'hFFFF_FFFF; when undefined, port and counter absent.

Structure
REQ-032 Shared package: FSM state enum, NOP encoding 32'h0000_0013, PC width 64, instruction width 32.
REQ-033 One sub-module natural: if_id_reg (IF/ID pipeline register with valid, load, consume, flush).

Verification
REQ-034 Reset release, RESET_PC=64'h1000, gnt=1, rvalid next cycle, predicted_pc=64'h1004 -> imem_addr 64'h1000 then 64'h1004; id_pc=64'h1000.
REQ-035 id_ready=0 with id_valid=1 -> imem_req=0, pc_q stable until id_ready=1.
REQ-036 Redirect to 64'h2000 in WAIT, rvalid one cycle later -> id_valid stays 0, next imem_addr 64'h2000 (DROP exercised).
REQ-037 Redirect same cycle as rvalid -> rdata discarded, next imem_addr = redirect_pc, no DROP.
REQ-038 pc_q=64'hFFFF_FFFF_FFFF_FFFC, predicted_pc=64'h0 -> next imem_addr 64'h0.
REQ-039 FETCH_MISPREDICT_CNT_EN defined, 3 redirect pulses -> mispredict_cnt=3; reset mid-run -> 0.
